// File: rtl/rv32im_ifu_pkg.sv
// rtl/rv32im_ifu_pkg.sv - shared widths, reset PC, buffer depth and FSM encoding for the fetch unit
package rv32im_ifu_pkg;

  localparam int          API_ADDR_WIDTH = 32;
  localparam int          API_DATA_WIDTH = 32;
  localparam logic [31:0] API_RESET_PC   = 32'h0000_0000;
  localparam int          IFU_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IFU_ST_RUN   = 2'd0,
    IFU_ST_FLUSH = 2'd1,
    IFU_ST_EXC   = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/rv32im_fetch_fifo.sv
// rtl/rv32im_fetch_fifo.sv - small synchronous FIFO with flush, used for fetch buffer and PC queue
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        empties the FIFO; a push in the same cycle lands as the only entry
//   push, wdata  write side
//   pop, rdata   read side; rdata is the registered head entry
//   count        entries held; full/empty derived from it
module rv32im_fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      if (push) begin
        mem[0] <= wdata;
        wr_ptr <= ptr_inc('0);
        count  <= CNT_W'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rv32im_ifu.sv
// rtl/rv32im_ifu.sv - instruction fetch unit: PC, in-order imem fetch, fetch buffer, redirect/kill
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   imem_req_o/addr_o/gnt_i        fetch request handshake (address held until granted)
//   imem_rvalid_i/rdata_i          in-order fetch responses
//   redir_i/redir_pc_i             redirect from the branch unit
//   if_valid_o/ready_i             decode handshake (pop on valid & ready)
//   if_instr_o/pc_o/exc_o          buffered instruction, its PC, misaligned-target flag
module rv32im_ifu
  import rv32im_ifu_pkg::*;
#(
  parameter int                ADDR_W     = API_ADDR_WIDTH,
  parameter int                DATA_W     = API_DATA_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = API_RESET_PC,
  parameter int                FIFO_DEPTH = IFU_FIFO_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              redir_i,
  input  logic [ADDR_W-1:0] redir_pc_i,
  output logic              if_valid_o,
  input  logic              if_ready_i,
  output logic [DATA_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic              if_exc_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W + 1;

  ifu_state_e        state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [CNT_W-1:0]  out_q, out_n;
  logic [CNT_W-1:0]  kill_q, kill_n;
  logic              req_q, req_n;
  logic              exc_owed_q, exc_owed_n;

  logic              misaligned;
  logic              gnt_acc;
  logic              resp_keep;
  logic              exc_push;
  logic              pcq_push;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]  fifo_count, fifo_count_n;
  logic              head_exc;

  logic [ADDR_W-1:0] pcq_rdata;
  logic [CNT_W-1:0]  pcq_count;
  logic              pcq_full, pcq_empty;
  logic              unused;

  assign misaligned = (redir_pc_i[1:0] != 2'b00);
  assign gnt_acc    = req_q && imem_gnt_i;
  assign resp_keep  = imem_rvalid_i && (kill_q == '0) && !redir_i;
  assign fifo_pop   = if_ready_i && !fifo_empty && !redir_i;
  // Fetches granted in a redirect cycle are stale, so their PC is never queued.
  assign pcq_push   = gnt_acc && !redir_i;

  always_comb begin
    out_n      = out_q + CNT_W'(gnt_acc) - CNT_W'(imem_rvalid_i);
    kill_n     = kill_q;
    if (imem_rvalid_i && (kill_q != '0)) begin
      kill_n = kill_q - CNT_W'(1);
    end
    pc_n       = gnt_acc ? pc_q + ADDR_W'(4) : pc_q;
    state_n    = state_q;
    exc_owed_n = exc_owed_q;
    exc_push   = 1'b0;

    if (redir_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      kill_n     = out_n;
      pc_n       = redir_pc_i;
      exc_owed_n = misaligned && (out_n != '0);
      exc_push   = misaligned && (out_n == '0);
      if (misaligned) begin
        state_n = IFU_ST_EXC;
      end else if (out_n != '0) begin
        state_n = IFU_ST_FLUSH;
      end else begin
        state_n = IFU_ST_RUN;
      end
    end else begin
      case (state_q)
        IFU_ST_FLUSH: begin
          if (kill_n == '0) begin
            state_n = IFU_ST_RUN;
          end
        end
        IFU_ST_EXC: begin
          // The misaligned entry is presented once the last stale response is gone.
          if (exc_owed_q && (kill_n == '0)) begin
            exc_push   = 1'b1;
            exc_owed_n = 1'b0;
          end
        end
        default: ;
      endcase
    end

    fifo_push  = resp_keep || exc_push;
    fifo_wdata = exc_push ? {pc_n, {DATA_W{1'b0}}, 1'b1}
                          : {pcq_rdata, imem_rdata_i, 1'b0};

    // Request is registered, so the credit test looks at next-cycle occupancy.
    fifo_count_n = redir_i ? '0 : fifo_count - CNT_W'(fifo_pop);
    fifo_count_n = fifo_count_n + CNT_W'(fifo_push);
    req_n = (state_n == IFU_ST_RUN) &&
            (({1'b0, out_n} + {1'b0, fifo_count_n}) < (CNT_W + 1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IFU_ST_RUN;
      pc_q       <= RESET_PC;
      out_q      <= '0;
      kill_q     <= '0;
      req_q      <= 1'b0;
      exc_owed_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      out_q      <= out_n;
      kill_q     <= kill_n;
      req_q      <= req_n;
      exc_owed_q <= exc_owed_n;
    end
  end

  rv32im_fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_pc_queue (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .flush (redir_i),
    .push  (pcq_push),
    .wdata (pc_q),
    .pop   (resp_keep),
    .rdata (pcq_rdata),
    .count (pcq_count),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  rv32im_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_buf (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .flush (redir_i),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign unused = &{1'b0, pcq_count, pcq_full, pcq_empty, fifo_full};

  assign imem_req_o                       = req_q;
  assign imem_addr_o                      = pc_q;
  assign if_valid_o                       = !fifo_empty;
  assign {if_pc_o, if_instr_o, head_exc} = fifo_rdata;
  assign if_exc_o                         = head_exc && !fifo_empty;

endmodule

// File: tb/tb_rv32im_ifu.sv
// tb/tb_rv32im_ifu.sv - directed self-checking bench for rv32im_ifu
module tb_rv32im_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redir_i;
  logic [31:0] redir_pc_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        if_exc_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  logic [31:0] glog[$];
  logic [31:0] rq_addr[$];
  int          rq_due[$];
  logic [31:0] dpc[$];
  logic [31:0] dinstr[$];
  logic        dexc[$];

  always #5 clk = ~clk;

  rv32im_ifu dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redir_i       (redir_i),
    .redir_pc_i    (redir_pc_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_exc_o      (if_exc_o)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log this cycle's grant and pop, advance, then drive the in-order memory response.
  task automatic tick();
    if (imem_req_o && imem_gnt_i) begin
      glog.push_back(imem_addr_o);
      rq_addr.push_back(imem_addr_o);
      rq_due.push_back(cyc + lat);
    end
    if (if_valid_o && if_ready_i && !redir_i) begin
      dpc.push_back(if_pc_o);
      dinstr.push_back(if_instr_o);
      dexc.push_back(if_exc_o);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = word_of(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    redir_i       = 1'b0;
    redir_pc_i    = '0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    glog.delete();
    rq_addr.delete();
    rq_due.delete();
    dpc.delete();
    dinstr.delete();
    dexc.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redir_i    = 1'b1;
    redir_pc_i = target;
    tick();
    redir_i    = 1'b0;
  endtask

  initial begin
    imem_gnt_i = 1'b1;
    if_ready_i = 1'b1;

    // Reset state
    do_reset();
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", if_valid_o, 0);
    chk("rst_exc", if_exc_o, 0);
    chk("rst_instr", if_instr_o, 32'h0);
    chk("rst_pc", if_pc_o, 32'h0);

    // 1: streaming fetch from reset PC
    lat = 1;
    repeat (14) tick();
    chk("t1_gaddr0", glog[0], 32'h0);
    chk("t1_gaddr1", glog[1], 32'h4);
    chk("t1_gaddr2", glog[2], 32'h8);
    chk("t1_gaddr3", glog[3], 32'hC);
    chk("t1_pc0", dpc[0], 32'h0);
    chk("t1_pc1", dpc[1], 32'h4);
    chk("t1_pc2", dpc[2], 32'h8);
    chk("t1_pc4", dpc[4], 32'h10);
    chk("t1_instr0", dinstr[0], 32'hC0DE_0000);
    chk("t1_instr2", dinstr[2], 32'hC0DE_0008);
    chk("t1_exc0", dexc[0], 0);

    // 2: decode stalled, then resumes with nothing lost
    do_reset();
    if_ready_i = 1'b0;
    repeat (10) tick();
    chk("t2_ngrant", glog.size(), 2);
    chk("t2_req_held", imem_req_o, 0);
    chk("t2_valid", if_valid_o, 1);
    chk("t2_head_pc", if_pc_o, 32'h0);
    chk("t2_head_instr", if_instr_o, 32'hC0DE_0000);
    if_ready_i = 1'b1;
    repeat (10) tick();
    chk("t2_pc0", dpc[0], 32'h0);
    chk("t2_pc1", dpc[1], 32'h4);
    chk("t2_pc2", dpc[2], 32'h8);
    chk("t2_pc3", dpc[3], 32'hC);
    chk("t2_gaddr2", glog[2], 32'h8);

    // 3: redirect with two fetches outstanding
    do_reset();
    lat = 3;
    redirect(32'h10);
    tick();
    tick();
    chk("t3_req_full", imem_req_o, 0);
    chk("t3_ngrant", glog.size(), 2);
    chk("t3_gaddr1", glog[1], 32'h14);
    redirect(32'h100);
    repeat (12) tick();
    chk("t3_gaddr2", glog[2], 32'h100);
    chk("t3_gaddr3", glog[3], 32'h104);
    chk("t3_pc0", dpc[0], 32'h100);
    chk("t3_instr0", dinstr[0], 32'hC0DE_0100);
    chk("t3_pc1", dpc[1], 32'h104);

    // 4a: redirect with the buffer full; same-cycle pop is ignored
    do_reset();
    lat = 1;
    if_ready_i = 1'b0;
    repeat (4) tick();
    chk("t4a_valid_full", if_valid_o, 1);
    chk("t4a_req_full", imem_req_o, 0);
    if_ready_i = 1'b1;
    redirect(32'h80);
    if_ready_i = 1'b0;
    chk("t4a_valid_after", if_valid_o, 0);
    chk("t4a_no_pop", dpc.size(), 0);
    chk("t4a_req", imem_req_o, 1);
    chk("t4a_addr", imem_addr_o, 32'h80);

    // 4b: redirect in the same cycle as a grant and a response
    do_reset();
    lat = 1;
    tick();
    tick();
    chk("t4b_req_pre", imem_req_o, 1);
    chk("t4b_addr_pre", imem_addr_o, 32'h4);
    redirect(32'h40);
    chk("t4b_valid", if_valid_o, 0);
    chk("t4b_req_kill", imem_req_o, 0);
    tick();
    chk("t4b_req", imem_req_o, 1);
    chk("t4b_addr", imem_addr_o, 32'h40);
    if_ready_i = 1'b1;
    repeat (6) tick();
    chk("t4b_pc0", dpc[0], 32'h40);
    chk("t4b_instr0", dinstr[0], 32'hC0DE_0040);

    // 5: misaligned redirect with one stale fetch in flight
    do_reset();
    lat = 2;
    if_ready_i = 1'b0;
    tick();
    redirect(32'h202);
    chk("t5_valid_c", if_valid_o, 0);
    chk("t5_req_c", imem_req_o, 0);
    tick();
    chk("t5_valid_d", if_valid_o, 0);
    tick();
    chk("t5_valid", if_valid_o, 1);
    chk("t5_exc", if_exc_o, 1);
    chk("t5_pc", if_pc_o, 32'h202);
    chk("t5_instr", if_instr_o, 32'h0);
    repeat (3) tick();
    chk("t5_held", if_valid_o, 1);
    chk("t5_ngrant", glog.size(), 1);
    if_ready_i = 1'b1;
    tick();
    chk("t5_valid_pop", if_valid_o, 0);
    chk("t5_exc_pop", if_exc_o, 0);
    chk("t5_dexc", dexc[0], 1);
    chk("t5_dpc", dpc[0], 32'h202);
    repeat (3) tick();
    chk("t5_idle_valid", if_valid_o, 0);
    chk("t5_idle_ngrant", glog.size(), 1);
    redirect(32'h300);
    chk("t5_req_resume", imem_req_o, 1);
    chk("t5_addr_resume", imem_addr_o, 32'h300);
    repeat (6) tick();
    chk("t5_pc1", dpc[1], 32'h300);
    chk("t5_instr1", dinstr[1], 32'hC0DE_0300);
    chk("t5_exc1", dexc[1], 0);

    // 6: PC wrap at top of address space, then asynchronous reset mid-stream
    do_reset();
    lat = 1;
    if_ready_i = 1'b1;
    redirect(32'hFFFF_FFFC);
    repeat (8) tick();
    chk("t6_gaddr0", glog[0], 32'hFFFF_FFFC);
    chk("t6_gaddr1", glog[1], 32'h0);
    chk("t6_pc0", dpc[0], 32'hFFFF_FFFC);
    chk("t6_pc1", dpc[1], 32'h0);
    chk("t6_instr0", dinstr[0], 32'h3F21_FFFC);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", imem_req_o, 0);
    chk("t6_rst_addr", imem_addr_o, 32'h0);
    chk("t6_rst_valid", if_valid_o, 0);
    chk("t6_rst_exc", if_exc_o, 0);
    chk("t6_rst_instr", if_instr_o, 32'h0);
    chk("t6_rst_pc", if_pc_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
